// File: rtl/mem_pkg.sv
// Shared types and constants for the parametrised data/instruction memory.
//   mem_state_t : init/boot/ready FSM states
//   OP_*        : opcode field values used to build the boot image
//   BOOT_W*     : boot image words loaded at BOOT_BASE after reset
package mem_pkg;

    typedef enum logic [1:0] {
        INIT_CLR,
        INIT_BOOT,
        READY
    } mem_state_t;

    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;

    // Tiny program: two constants, two loads of them, then their sum into r4.
    localparam logic [31:0] BOOT_W0 = 32'd5;
    localparam logic [31:0] BOOT_W1 = 32'd4;
    localparam logic [31:0] BOOT_W2 = {OP_LW, 5'd0, 5'd2, 16'd105};           // lw  r2,105
    localparam logic [31:0] BOOT_W3 = {OP_LW, 5'd0, 5'd3, 16'd106};           // lw  r3,106
    localparam logic [31:0] BOOT_W4 = {OP_RTYPE, 5'd2, 5'd3, 5'd4, 5'd0, 6'd0}; // add r4,r2,r3

endpackage

// File: rtl/mem_boot_rom.sv
// Combinational boot image ROM.
//   idx  in  IDX_W   boot word index (0..BOOT_LEN-1)
//   word out DATA_W  boot word; indices beyond the image return 0
module mem_boot_rom
    import mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int BOOT_LEN = 5,
    parameter int IDX_W    = (BOOT_LEN > 1) ? $clog2(BOOT_LEN) : 1
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] word
);

    always_comb begin
        word = '0;
        if (int'(idx) < BOOT_LEN) begin
            case (int'(idx))
                0:       word = DATA_W'(BOOT_W0);
                1:       word = DATA_W'(BOOT_W1);
                2:       word = DATA_W'(BOOT_W2);
                3:       word = DATA_W'(BOOT_W3);
                4:       word = DATA_W'(BOOT_W4);
                default: word = '0;
            endcase
        end
    end

endmodule

// File: rtl/param_data_memory.sv
// Single-port word-addressed data/instruction memory with boot loader.
// After reset an init FSM optionally clears the array, then copies the boot
// image to BOOT_BASE; only then are requests accepted (memReady=1).
//   clk, reset       : clock, synchronous active-high reset
//   address, data    : word address / write data of the request
//   memRead/memWrite : request strobes, honoured only while memReady=1
//   memReady         : FSM is in READY
//   memOut/memValid  : read data, valid pulse READ_LAT cycles after the request
//   memErr           : pulse one cycle after an accepted out-of-range request
// Build option: define MEM_CLEAR_EN to zero the whole array before booting.
module param_data_memory
    import mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 256,
    parameter int READ_LAT  = 1,
    parameter int BOOT_BASE = 105,
    parameter int BOOT_LEN  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              memRead,
    input  logic              memWrite,
    output logic              memReady,
    output logic [DATA_W-1:0] memOut,
    output logic              memValid,
    output logic              memErr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BI_W  = (BOOT_LEN > 1) ? $clog2(BOOT_LEN) : 1;
    localparam logic [ADDR_W:0] DEPTH_X     = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] BOOT_BASE_I = IDX_W'(BOOT_BASE);

`ifdef MEM_CLEAR_EN
    localparam mem_state_t INIT_STATE = INIT_CLR;
`else
    localparam mem_state_t INIT_STATE = INIT_BOOT;
`endif

    logic [DATA_W-1:0] ram [DEPTH];

    mem_state_t        state, state_nxt;
    logic [IDX_W-1:0]  cnt, cnt_nxt;
    logic              init_we;
    logic [IDX_W-1:0]  init_addr;
    logic [DATA_W-1:0] init_wdata;
    logic [DATA_W-1:0] boot_word;

    logic              accept, in_range, rd_acc, req_err;
    logic [IDX_W-1:0]  addr_idx;
    logic [DATA_W-1:0] rd_word;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    logic [READ_LAT:1]             vld_pipe;
    logic [READ_LAT:1][DATA_W-1:0] dat_pipe;
    logic                          err_q;

    mem_boot_rom #(
        .DATA_W   (DATA_W),
        .BOOT_LEN (BOOT_LEN),
        .IDX_W    (BI_W)
    ) u_boot_rom (
        .idx  (cnt[BI_W-1:0]),
        .word (boot_word)
    );

    // ---------------- init FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        init_we    = 1'b0;
        init_addr  = cnt;
        init_wdata = '0;
        case (state)
`ifdef MEM_CLEAR_EN
            INIT_CLR: begin
                init_we = 1'b1;
                if (cnt == IDX_W'(DEPTH-1)) begin
                    state_nxt = INIT_BOOT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`endif
            INIT_BOOT: begin
                init_we    = 1'b1;
                init_addr  = BOOT_BASE_I + cnt;
                init_wdata = boot_word;
                if (cnt == IDX_W'(BOOT_LEN-1)) begin
                    state_nxt = READY;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            READY:   state_nxt = READY;
            default: state_nxt = INIT_BOOT;
        endcase
    end

    // ---------------- request decode ----------------
    assign accept   = (state == READY);
    assign addr_idx = address[IDX_W-1:0];
    // Full-width compare so high address bits never alias into the array.
    assign in_range = ({1'b0, address} < DEPTH_X);
    assign rd_acc   = accept & memRead;
    assign req_err  = accept & (memRead | memWrite) & ~in_range;

    // Init writes only happen outside READY, user writes only inside it.
    always_comb begin
        ram_we    = init_we;
        ram_waddr = init_addr;
        ram_wdata = init_wdata;
        if (accept && memWrite && in_range) begin
            ram_we    = 1'b1;
            ram_waddr = addr_idx;
            ram_wdata = data;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_waddr] <= ram_wdata;
    end

    // Write-first: a simultaneous write is forwarded to the read.
    always_comb begin
        rd_word = '0;
        if (in_range)
            rd_word = memWrite ? data : ram[addr_idx];
    end

    // ---------------- read pipeline ----------------
    // Each data stage only loads when a read enters it, so the last stage
    // holds the most recent read value between valid pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
            err_q    <= 1'b0;
        end else begin
            vld_pipe[1] <= rd_acc;
            if (rd_acc)
                dat_pipe[1] <= rd_word;
            for (int i = 2; i <= READ_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1])
                    dat_pipe[i] <= dat_pipe[i-1];
            end
            err_q <= req_err;
        end
    end

    assign memReady = accept;
    assign memValid = vld_pipe[READ_LAT];
    assign memOut   = dat_pipe[READ_LAT];
    assign memErr   = err_q;

endmodule

// File: tb/tb_param_data_memory.sv
// Directed bench: two instances (READ_LAT=1 and 2) share one stimulus stream.
module tb_param_data_memory;

    localparam int DEPTH    = 256;
    localparam int BOOT_LEN = 5;
`ifdef MEM_CLEAR_EN
    localparam int READY_CYC = DEPTH + BOOT_LEN;
`else
    localparam int READY_CYC = BOOT_LEN;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data = '0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;

    logic        rdy1, v1, e1, rdy2, v2, e2;
    logic [31:0] o1, o2;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    param_data_memory #(.READ_LAT(1)) u_l1 (
        .clk(clk), .reset(reset), .address(address), .data(data),
        .memRead(memRead), .memWrite(memWrite), .memReady(rdy1),
        .memOut(o1), .memValid(v1), .memErr(e1)
    );

    param_data_memory #(.READ_LAT(2)) u_l2 (
        .clk(clk), .reset(reset), .address(address), .data(data),
        .memRead(memRead), .memWrite(memWrite), .memReady(rdy2),
        .memOut(o2), .memValid(v2), .memErr(e2)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_vld;
        logic [31:0] exp_out;
        logic        exp_err;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Inputs change 1 time unit after the active edge; outputs are sampled there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memRead = 1'b0; memWrite = 1'b0; address = '0; data = '0;
    endtask

    // Count cycles to memReady while optionally hammering requests that must be ignored.
    task automatic wait_ready(input bit req);
        int n = 0;
        int bad = 0;
        do begin
            if (req) begin
                memRead = 1'b1; memWrite = 1'b1; data = 32'h55;
                address = n[0] ? 32'd300 : 32'd10;
            end
            tick();
            n++;
            if (v1 | v2 | e1 | e2 | (rdy1 != rdy2)) bad++;
        end while (!rdy1 && n < 2000);
        idle();
        chk("ready_latency", n, READY_CYC);
        chk("init_quiet", bad, 0);
    endtask

    task automatic do_op(input vec_t v, input int idx);
        memRead = v.rd; memWrite = v.wr; address = v.addr; data = v.wdata;
        tick();
        idle();
        chk($sformatf("v%0d_valid_l1", idx), v1, v.exp_vld);
        if (v.exp_vld) chk($sformatf("v%0d_out_l1", idx), o1, v.exp_out);
        chk($sformatf("v%0d_valid_l2_early", idx), v2, 1'b0);
        chk($sformatf("v%0d_err_l1", idx), e1, v.exp_err);
        chk($sformatf("v%0d_err_l2", idx), e2, v.exp_err);
        tick();
        chk($sformatf("v%0d_valid_l2", idx), v2, v.exp_vld);
        if (v.exp_vld) chk($sformatf("v%0d_out_l2", idx), o2, v.exp_out);
        chk($sformatf("v%0d_valid_l1_late", idx), v1, 1'b0);
        chk($sformatf("v%0d_err_l1_late", idx), e1, 1'b0);
    endtask

    initial begin
        vec_t v;
        //          rd    wr    addr          wdata         vld   out           err
        vecs[0]  = '{1'b1, 1'b0, 32'd105,      32'h0,        1'b1, 32'd5,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'd106,      32'h0,        1'b1, 32'd4,        1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'd107,      32'h0,        1'b1, 32'h20020069, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'd108,      32'h0,        1'b1, 32'h2003006A, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'd109,      32'h0,        1'b1, 32'h00432000, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'd10,       32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'd10,       32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'd20,       32'h1234,     1'b1, 32'h1234,     1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'd0,        32'hA5A5A5A5, 1'b0, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'd256,      32'd7,        1'b0, 32'h0,        1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'd0,        32'h0,        1'b1, 32'hA5A5A5A5, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'd255,      32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'd255,      32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h8000000A, 32'h0BAD,     1'b0, 32'h0,        1'b1};
        vecs[14] = '{1'b1, 1'b0, 32'd10,       32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 32'd300,      32'h0,        1'b1, 32'h0,        1'b1};
        vecs[16] = '{1'b1, 1'b0, 32'd20,       32'h0,        1'b1, 32'h1234,     1'b0};

        // Reset state
        reset = 1'b1;
        tick();
        chk("rst_ready_l1", rdy1, 1'b0);
        chk("rst_ready_l2", rdy2, 1'b0);
        chk("rst_valid_l1", v1, 1'b0);
        chk("rst_valid_l2", v2, 1'b0);
        chk("rst_err_l1", e1, 1'b0);
        chk("rst_out_l1", o1, 32'h0);
        chk("rst_out_l2", o2, 32'h0);
        reset = 1'b0;
        wait_ready(1'b0);

`ifdef MEM_CLEAR_EN
        v = '{1'b1, 1'b0, 32'd0, 32'h0, 1'b1, 32'h0, 1'b0};
        do_op(v, 100);
`endif

        foreach (vecs[i]) do_op(vecs[i], i);

        // Back-to-back reads 105, 106
        memRead = 1'b1; address = 32'd105;
        tick();
        address = 32'd106;
        chk("b2b_c1_v1", v1, 1'b1); chk("b2b_c1_o1", o1, 32'd5);
        chk("b2b_c1_v2", v2, 1'b0);
        tick();
        idle();
        chk("b2b_c2_v1", v1, 1'b1); chk("b2b_c2_o1", o1, 32'd4);
        chk("b2b_c2_v2", v2, 1'b1); chk("b2b_c2_o2", o2, 32'd5);
        tick();
        chk("b2b_c3_v1", v1, 1'b0); chk("b2b_c3_o1_hold", o1, 32'd4);
        chk("b2b_c3_v2", v2, 1'b1); chk("b2b_c3_o2", o2, 32'd4);
        tick();
        chk("b2b_c4_v2", v2, 1'b0); chk("b2b_c4_o2_hold", o2, 32'd4);

        // Reset the cycle after a read is accepted: the READ_LAT=2 result is dropped
        memRead = 1'b1; address = 32'd105;
        tick();
        idle();
        reset = 1'b1;
        chk("midrst_v1_before", v1, 1'b1);
        tick();
        chk("midrst_v2_dropped", v2, 1'b0);
        chk("midrst_v1", v1, 1'b0);
        chk("midrst_o2", o2, 32'h0);
        chk("midrst_ready", rdy1, 1'b0);
        tick();
        chk("midrst_v2_still", v2, 1'b0);
        reset = 1'b0;
        wait_ready(1'b1);

        // Requests during init must not have written word 10 or 20
`ifdef MEM_CLEAR_EN
        v = '{1'b1, 1'b0, 32'd10, 32'h0, 1'b1, 32'h0, 1'b0};
        do_op(v, 200);
        v = '{1'b1, 1'b0, 32'd20, 32'h0, 1'b1, 32'h0, 1'b0};
        do_op(v, 201);
`else
        v = '{1'b1, 1'b0, 32'd10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0};
        do_op(v, 200);
        v = '{1'b1, 1'b0, 32'd20, 32'h0, 1'b1, 32'h1234, 1'b0};
        do_op(v, 201);
`endif
        v = '{1'b1, 1'b0, 32'd109, 32'h0, 1'b1, 32'h00432000, 1'b0};
        do_op(v, 202);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
